// File: rtl/ps2_key_state_decoder.sv
// ps2_key_state_decoder
//   Converts a PS/2 scan-code set 2 byte stream into a held-key bitmap plus a
//   one-cycle key event for every key_state change.
//   Understands make codes, F0 break codes, E0 extended codes, E0 F0
//   extended breaks and the E1 Pause sequence (E1 plus 7 bytes, swallowed).
//   The key map comes from parameters: KEY_CODES holds one byte per key and
//   KEY_EXT holds one E0-required flag per key.
//
// Optional feature: define PS2_TYPEMATIC_FILTER_EN to suppress events for
//   typematic repeats (make of a key already held) and for breaks of keys
//   that are not held.
//
// Ports
//   clk             in   system clock
//   reset           in   synchronous, active-high reset
//   byte_valid      in   one-cycle strobe, key_byte valid
//   key_byte        in   received scan-code byte
//   key_state       out  [NUM_KEYS] 1 = key held
//   key_event_valid out  one-cycle pulse when a key_state bit event occurs
//   key_event_idx   out  index of the key for the event
//   key_event_make  out  1 = press, 0 = release
//   protocol_error  out  one-cycle pulse: illegal sequence, timeout or overflow
module ps2_key_state_decoder #(
    parameter int                    NUM_KEYS       = 12,
    parameter logic [NUM_KEYS*8-1:0] KEY_CODES      = 96'h74_72_6B_75_2B_23_1B_1C_2C_2D_24_1D,
    parameter logic [NUM_KEYS-1:0]   KEY_EXT        = 12'hF00,
    parameter int                    TIMEOUT_CYCLES = 100000,
    localparam int                   IDXW           = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                byte_valid,
    input  logic [7:0]          key_byte,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                key_event_valid,
    output logic [IDXW-1:0]     key_event_idx,
    output logic                key_event_make,
    output logic                protocol_error
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_PAUSE
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          pause_q, pause_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [NUM_KEYS-1:0] ks_q, ks_d;
    logic                ev_v_q, ev_v_d;
    logic [IDXW-1:0]     ev_idx_q, ev_idx_d;
    logic                ev_make_q, ev_make_d;
    logic                err_q, err_d;

    // Key table lookup; the extended flag comes from the prefix state.
    logic            ext_sel;
    logic            hit;
    logic [IDXW-1:0] hit_idx;

    always_comb begin
        ext_sel = (state_q == S_EXT) || (state_q == S_EXT_BRK);
        hit     = 1'b0;
        hit_idx = '0;
        // Scan downward so the lowest matching index is the one that sticks.
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (KEY_CODES[i*8 +: 8] == key_byte && KEY_EXT[i] == ext_sel) begin
                hit     = 1'b1;
                hit_idx = IDXW'(i);
            end
        end
    end

    logic is_ovf, is_e0, is_f0, is_e1;
    assign is_ovf = (key_byte == 8'h00) || (key_byte == 8'hFF);
    assign is_e0  = (key_byte == 8'hE0);
    assign is_f0  = (key_byte == 8'hF0);
    assign is_e1  = (key_byte == 8'hE1);

    logic do_make, do_break;

    always_comb begin
        state_d   = state_q;
        pause_d   = pause_q;
        tmo_d     = tmo_q;
        ks_d      = ks_q;
        ev_v_d    = 1'b0;
        ev_idx_d  = ev_idx_q;
        ev_make_d = ev_make_q;
        err_d     = 1'b0;
        do_make   = 1'b0;
        do_break  = 1'b0;

        if (byte_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (is_e0)       state_d = S_EXT;
                    else if (is_f0)  state_d = S_BRK;
                    else if (is_e1) begin
                        state_d = S_PAUSE;
                        pause_d = 3'd7;
                    end else if (is_ovf) begin
                        err_d = 1'b1;
                        ks_d  = '0;
                    end else         do_make = 1'b1;
                end
                S_EXT: begin
                    state_d = S_IDLE;
                    if (is_f0)             state_d = S_EXT_BRK;
                    else if (is_e0 || is_e1) err_d = 1'b1;
                    else if (is_ovf) begin
                        err_d = 1'b1;
                        ks_d  = '0;
                    end else               do_make = 1'b1;
                end
                S_BRK, S_EXT_BRK: begin
                    state_d = S_IDLE;
                    if (is_e0 || is_f0 || is_e1) err_d = 1'b1;
                    else if (is_ovf) begin
                        err_d = 1'b1;
                        ks_d  = '0;
                    end else                     do_break = 1'b1;
                end
                S_PAUSE: begin
                    // Pause bytes are consumed blindly, whatever their value.
                    pause_d = pause_q - 3'd1;
                    if (pause_q <= 3'd1) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase

            if (do_make && hit) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                if (!ks_q[hit_idx]) begin
                    ev_v_d    = 1'b1;
                    ev_idx_d  = hit_idx;
                    ev_make_d = 1'b1;
                end
`else
                ev_v_d    = 1'b1;
                ev_idx_d  = hit_idx;
                ev_make_d = 1'b1;
`endif
                ks_d[hit_idx] = 1'b1;
            end

            if (do_break && hit) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                if (ks_q[hit_idx]) begin
                    ev_v_d    = 1'b1;
                    ev_idx_d  = hit_idx;
                    ev_make_d = 1'b0;
                end
`else
                ev_v_d    = 1'b1;
                ev_idx_d  = hit_idx;
                ev_make_d = 1'b0;
`endif
                ks_d[hit_idx] = 1'b0;
            end
        end

        // Inter-byte timeout: an arriving byte always takes precedence.
        if (byte_valid || state_q == S_IDLE) begin
            tmo_d = '0;
        end else if (TIMEOUT_CYCLES != 0) begin
            if (({{(32-TW){1'b0}}, tmo_q} + 32'd1) == TIMEOUT_CYCLES) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pause_q   <= '0;
            tmo_q     <= '0;
            ks_q      <= '0;
            ev_v_q    <= 1'b0;
            ev_idx_q  <= '0;
            ev_make_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pause_q   <= pause_d;
            tmo_q     <= tmo_d;
            ks_q      <= ks_d;
            ev_v_q    <= ev_v_d;
            ev_idx_q  <= ev_idx_d;
            ev_make_q <= ev_make_d;
            err_q     <= err_d;
        end
    end

    assign key_state       = ks_q;
    assign key_event_valid = ev_v_q;
    assign key_event_idx   = ev_idx_q;
    assign key_event_make  = ev_make_q;
    assign protocol_error  = err_q;

endmodule

// File: tb/tb_ps2_key_state_decoder.sv
// Scoreboard bench for ps2_key_state_decoder: directed sequences plus
// randomized byte streams, checked against a prefix-flag reference model.
module tb_ps2_key_state_decoder;

    localparam int T  = 20;
    localparam int NK = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          byte_valid;
    logic [7:0]    key_byte;
    logic [NK-1:0] key_state;
    logic          ev_v;
    logic [3:0]    ev_idx;
    logic          ev_make;
    logic          perr;

    always #5 clk = ~clk;

    ps2_key_state_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk            (clk),
        .reset          (reset),
        .byte_valid     (byte_valid),
        .key_byte       (key_byte),
        .key_state      (key_state),
        .key_event_valid(ev_v),
        .key_event_idx  (ev_idx),
        .key_event_make (ev_make),
        .protocol_error (perr)
    );

    typedef struct {
        bit            err;
        int            idx;
        bit            mk;
        logic [NK-1:0] ks;
        int            cyc;
    } exp_t;

    typedef struct {
        int            cyc;
        logic [NK-1:0] ks;
    } ks_t;

    exp_t q[$];
    ks_t  ksq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference key map (scan code, needs-E0)
    logic [7:0] codes [NK] = '{8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h1C, 8'h1B,
                               8'h23, 8'h2B, 8'h75, 8'h6B, 8'h72, 8'h74};
    bit         kext  [NK] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};

    // Model: which prefixes have been seen, Pause bytes still to swallow
    bit            m_e0, m_f0;
    int            m_pause;
    int            m_idle;
    logic [NK-1:0] m_held;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int lookup(input logic [7:0] b, input bit e);
        for (int i = 0; i < NK; i++)
            if (codes[i] == b && kext[i] == e) return i;
        return -1;
    endfunction

    task automatic push(input bit err, input int idx, input bit mk);
        exp_t x;
        x.err = err; x.idx = idx; x.mk = mk; x.ks = m_held; x.cyc = cyc + 1;
        q.push_back(x);
    endtask

    task automatic clr_prefix();
        m_e0 = 0; m_f0 = 0; m_pause = 0; m_idle = 0;
    endtask

    task automatic model_key(input bit brk, input logic [7:0] b, input bit e);
        int i;
        i = lookup(b, e);
        if (i < 0) return;
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (brk ? m_held[i] : !m_held[i]) begin
            m_held[i] = !brk;
            push(0, i, !brk);
        end
`else
        m_held[i] = !brk;
        push(0, i, !brk);
`endif
    endtask

    task automatic send(input logic [7:0] b);
        ks_t k;
        @(negedge clk);
        byte_valid = 1'b1;
        key_byte   = b;
        m_idle     = 0;
        if (m_pause > 0) begin
            m_pause--;
        end else if (b == 8'h00 || b == 8'hFF) begin
            m_held = '0;
            clr_prefix();
            push(1, 0, 0);
        end else if (m_f0) begin
            if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1) push(1, 0, 0);
            else model_key(1, b, m_e0);
            clr_prefix();
        end else if (m_e0) begin
            if (b == 8'hF0) m_f0 = 1;
            else begin
                if (b == 8'hE0 || b == 8'hE1) push(1, 0, 0);
                else model_key(0, b, 1);
                clr_prefix();
            end
        end else begin
            if (b == 8'hE0)      m_e0 = 1;
            else if (b == 8'hF0) m_f0 = 1;
            else if (b == 8'hE1) m_pause = 7;
            else                 model_key(0, b, 0);
        end
        k.cyc = cyc + 1;
        k.ks  = m_held;
        ksq.push_back(k);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            byte_valid = 1'b0;
            if (m_e0 || m_f0 || m_pause > 0) begin
                m_idle++;
                if (m_idle == T) begin
                    clr_prefix();
                    push(1, 0, 0);
                end
            end
        end
    endtask

    task automatic do_reset();
        idle(3);
        chk("drain_before_reset", q.size(), 0);
        @(negedge clk);
        reset      = 1'b1;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_key_state", int'(key_state), 0);
        chk("rst_event_valid", int'(ev_v), 0);
        chk("rst_event_idx", int'(ev_idx), 0);
        chk("rst_event_make", int'(ev_make), 0);
        chk("rst_protocol_error", int'(perr), 0);
        reset = 1'b0;
        clr_prefix();
        m_held = '0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output
    always @(negedge clk) begin
        if (ev_v || perr) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: ev_v=%0d idx=%0d make=%0d perr=%0d, expected none (cycle %0d)",
                         ev_v, ev_idx, ev_make, perr, cyc);
            end else begin
                exp_t x;
                x = q.pop_front();
                chk("out_kind", int'({ev_v, perr}), x.err ? 1 : 2);
                if (!x.err) begin
                    chk("event_idx", int'(ev_idx), x.idx);
                    chk("event_make", int'(ev_make), int'(x.mk));
                end
                chk("out_key_state", int'(key_state), int'(x.ks));
                chk("out_latency_cycle", cyc, x.cyc);
            end
        end
        while (ksq.size() > 0 && ksq[0].cyc <= cyc) begin
            ks_t k;
            k = ksq.pop_front();
            chk("key_state_after_byte", int'(key_state), int'(k.ks));
        end
    end

    initial begin
        logic [7:0] pause_seq [7] = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        reset      = 1'b1;
        byte_valid = 1'b0;
        key_byte   = 8'h00;
        clr_prefix();
        m_held = '0;
        repeat (2) @(negedge clk);
        chk("init_key_state", int'(key_state), 0);
        chk("init_outputs", int'({ev_v, ev_make, perr}), 0);
        reset = 1'b0;

        // Directed sequences
        send(8'h1D); idle(2);
        send(8'hF0); send(8'h1D); idle(2);
        send(8'hE0); send(8'h75); idle(1);
        send(8'hE0); send(8'hF0); send(8'h75); idle(1);
        send(8'h75); idle(1);
        send(8'h24); send(8'h24); send(8'h24); idle(1);
        send(8'hF0); send(8'h2D); idle(1);          // break of key never pressed
        send(8'hAA); send(8'hFA); send(8'hFE); send(8'hEE); send(8'h55);
        send(8'hE1);
        for (int i = 0; i < 7; i++) send(pause_seq[i]);
        send(8'h1C); idle(1);
        send(8'hF0); idle(T + 3);
        send(8'h1D); idle(1);
        send(8'hE0); idle(T - 1); send(8'h74); idle(1);  // byte just before timeout
        send(8'hFF); idle(1);
        send(8'hF0); send(8'hF0); idle(1);
        send(8'hE0); send(8'hE0); send(8'h00); idle(1);
        send(8'hE0); do_reset();                          // reset mid-sequence
        send(8'h75); idle(1);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 50)      send(codes[$urandom_range(0, NK - 1)]);
            else if (r < 64) send(8'hF0);
            else if (r < 76) send(8'hE0);
            else if (r < 79) send(8'hE1);
            else if (r < 81) send(($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00);
            else if (r < 88) send(8'($urandom_range(0, 255)));
            else if (r < 96) idle($urandom_range(1, 5));
            else if (r < 99) idle($urandom_range(T - 2, T + 3));
            else             do_reset();
        end

        idle(5);
        chk("scoreboard_empty", q.size(), 0);
        chk("final_key_state", int'(key_state), int'(m_held));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
